// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO controllers: output-stage state,
// depth helper and the modular pointer difference used by both pointer sides.
package fifo_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // (a - b) modulo 2^width; pointers carry a wrap bit so width is ADDR_WIDTH+1.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: owns the read pointer and a first-word-fall-through
// output register. Optional overflow detection with `define FIFO_RD_ERR_EN.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  empty,
  output logic [ADDR_WIDTH+1:0] rd_count,
  output logic                  dbg_state
`ifdef FIFO_RD_ERR_EN
  ,
  output logic                  rd_err
`endif
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int CW = ADDR_WIDTH + 2;

  out_state_e      state;
  logic [PW-1:0]   avail;
  logic            fetch;

  assign avail    = PW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), PW));
  assign rd_addr  = rd_ptr[ADDR_WIDTH-1:0];
  assign m_valid  = (state == FULL);
  assign dbg_state = state;
  assign rd_count = CW'(avail) + CW'(m_valid);
  assign empty    = (rd_count == '0);

  // Stream handshake: a beat transfers on any edge where m_valid && m_ready.
  // Once m_valid is high, m_data and m_valid hold until that transfer; m_valid
  // never depends combinationally on m_ready. A refill may replace the word in
  // the same cycle it is consumed, giving one beat per cycle.
`ifdef FIFO_RD_ERR_EN
  logic over_depth;
  assign over_depth = (CW'(avail) > CW'(DEPTH));
  assign fetch = (avail != '0) && !over_depth && (!m_valid || m_ready);

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      rd_err <= 1'b0;
    end else if (over_depth) begin
      rd_err <= 1'b1;
    end
  end
`else
  assign fetch = (avail != '0) && (!m_valid || m_ready);
`endif

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      state  <= EMPTY;
      rd_ptr <= '0;
      m_data <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (fetch) begin
            state  <= FULL;
            m_data <= ram_dout;
            rd_ptr <= rd_ptr + PW'(1);
          end
        end
        FULL: begin
          // fetch here implies m_ready, so the held word is replaced in place.
          if (fetch) begin
            m_data <= ram_dout;
            rd_ptr <= rd_ptr + PW'(1);
          end else if (m_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: a RAM array and writer live in the bench;
// a queue of written words is the reference for order, count and stall hold.
module tb_fifo_rd_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] ram_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          empty;
  logic [AW+1:0] rd_count;
  logic          dbg_state;
`ifdef FIFO_RD_ERR_EN
  logic          rd_err;
`endif

  logic [DW-1:0] ram [DEPTH];
  assign ram_dout = ram[rd_addr];

  always #5 rd_clk = ~rd_clk;

  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .rd_clk   (rd_clk),
    .rd_rst_n (rd_rst_n),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .rd_addr  (rd_addr),
    .ram_dout (ram_dout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .empty    (empty),
    .rd_count (rd_count),
    .dbg_state(dbg_state)
`ifdef FIFO_RD_ERR_EN
    ,
    .rd_err   (rd_err)
`endif
  );

  int            errors;
  int            checks;
  logic [DW-1:0] exp_q[$];
  int            written;
  int            popped;
  bit            prev_stall;
  logic [DW-1:0] prev_data;

  // One cycle, entered and left at a falling edge: check, drive, predict pop.
  task automatic step(input bit do_wr, input logic [DW-1:0] d, input bit rdy);
    checks++;
    if (rd_count !== (AW+2)'(written - popped)) begin
      errors++;
      $display("FAIL rd_count: got %0d expected %0d", rd_count, written - popped);
    end
    checks++;
    if (empty !== (written == popped)) begin
      errors++;
      $display("FAIL empty: got %0b expected %0b", empty, written == popped);
    end
    if (prev_stall) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== prev_data) begin
        errors++;
        $display("FAIL stall_hold: got valid=%0b data=%h expected valid=1 data=%h",
                 m_valid, m_data, prev_data);
      end
    end
    if (do_wr) begin
      ram[wr_ptr[AW-1:0]] = d;
      exp_q.push_back(d);
      wr_ptr = wr_ptr + 5'd1;
      written++;
    end
    m_ready = rdy;
    if (m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_order: got unexpected beat %h expected no beat", m_data);
      end else begin
        if (m_data !== exp_q[0]) begin
          errors++;
          $display("FAIL pop_order: got %h expected %h", m_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      popped++;
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    @(posedge rd_clk);
    @(negedge rd_clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 100) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rd_rst_n = 1'b0;
    wr_ptr   = '0;
    m_ready  = 1'b0;
    @(negedge rd_clk);
    @(negedge rd_clk);
    exp_q.delete();
    written    = 0;
    popped     = 0;
    prev_stall = 1'b0;
    rd_rst_n   = 1'b1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] w0;
    rd_rst_n = 1'b0;
    wr_ptr   = '0;
    m_ready  = 1'b0;
    @(negedge rd_clk);
    @(negedge rd_clk);
    checks++;
    if (m_valid !== 1'b0 || rd_ptr !== 5'd0 || m_data !== 8'h00 ||
        rd_count !== 6'd0 || empty !== 1'b1 || rd_addr !== 4'd0) begin
      errors++;
      $display("FAIL reset_values: got valid=%0b ptr=%0d data=%h cnt=%0d empty=%0b addr=%0d expected 0 0 00 0 1 0",
               m_valid, rd_ptr, m_data, rd_count, empty, rd_addr);
    end
    for (int i = 0; i < 5; i++) ram[i] = 8'($urandom_range(0, 255));
    w0 = ram[0];
    wr_ptr = 5'd5;
    repeat (3) @(negedge rd_clk);
    checks++;
    if (m_valid !== 1'b0 || rd_ptr !== 5'd0 || rd_count !== 6'd5) begin
      errors++;
      $display("FAIL reset_hold: got valid=%0b ptr=%0d cnt=%0d expected 0 0 5",
               m_valid, rd_ptr, rd_count);
    end
    rd_rst_n = 1'b1;
    @(negedge rd_clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== w0 || rd_ptr !== 5'd1) begin
      errors++;
      $display("FAIL reset_release: got valid=%0b data=%h ptr=%0d expected 1 %h 1",
               m_valid, m_data, rd_ptr, w0);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b1, 8'hA5, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || rd_ptr !== 5'd1 || rd_count !== 6'd1) begin
      errors++;
      $display("FAIL single_word: got valid=%0b data=%h ptr=%0d cnt=%0d expected 1 a5 1 1",
               m_valid, m_data, rd_ptr, rd_count);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b0);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'hA5 || rd_ptr !== 5'd1) begin
        errors++;
        $display("FAIL single_hold: got valid=%0b data=%h ptr=%0d expected 1 a5 1",
                 m_valid, m_data, rd_ptr);
      end
    end
    drain();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    checks++;
    if (rd_ptr !== 5'd1 || rd_count !== 6'd16) begin
      errors++;
      $display("FAIL stream_fill: got ptr=%0d cnt=%0d expected 1 16", rd_ptr, rd_count);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (m_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_beat: beat %0d got valid=%0b expected 1", i, m_valid);
      end
      step(1'b0, '0, 1'b1);
    end
    checks++;
    if (m_valid !== 1'b0 || empty !== 1'b1 || rd_ptr !== 5'd16) begin
      errors++;
      $display("FAIL stream_end: got valid=%0b empty=%0b ptr=%0d expected 0 1 16",
               m_valid, empty, rd_ptr);
    end
  endtask

  task automatic test_stall_full();
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    checks++;
    if (rd_count !== 6'd17 || rd_ptr !== 5'd1 || wr_ptr !== 5'd17) begin
      errors++;
      $display("FAIL stall_full: got cnt=%0d ptr=%0d expected 17 1", rd_count, rd_ptr);
    end
    step(1'b0, '0, 1'b1);
    checks++;
    if (rd_count !== 6'd16 || rd_ptr !== 5'd2 || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_one_pop: got cnt=%0d ptr=%0d valid=%0b expected 16 2 1",
               rd_count, rd_ptr, m_valid);
    end
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom_range(0, 8'hBF)), 1'b1);
    drain();
    checks++;
    if (rd_ptr !== 5'd30) begin
      errors++;
      $display("FAIL wrap_start: got ptr=%0d expected 30", rd_ptr);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b1);
    drain();
    checks++;
    if (rd_ptr !== 5'd2 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end: got ptr=%0d empty=%0b expected 2 1", rd_ptr, empty);
    end
  endtask

  task automatic test_random();
    bit wr;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      wr = (5'(wr_ptr - rd_ptr) < 5'd16) && ($urandom_range(0, 2) != 0);
      step(wr, 8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
    end
    drain();
  endtask

`ifdef FIFO_RD_ERR_EN
  task automatic test_err();
    do_reset();
    checks++;
    if (rd_err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: got %0b expected 0", rd_err);
    end
    wr_ptr = rd_ptr + 5'd17;
    @(negedge rd_clk);
    checks++;
    if (rd_err !== 1'b1 || m_valid !== 1'b0 || rd_ptr !== 5'd0) begin
      errors++;
      $display("FAIL err_set: got err=%0b valid=%0b ptr=%0d expected 1 0 0",
               rd_err, m_valid, rd_ptr);
    end
    wr_ptr = rd_ptr;
    repeat (3) @(negedge rd_clk);
    checks++;
    if (rd_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %0b expected 1", rd_err);
    end
    rd_rst_n = 1'b0;
    @(negedge rd_clk);
    checks++;
    if (rd_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %0b expected 0", rd_err);
    end
    do_reset();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    errors     = 0;
    checks     = 0;
    written    = 0;
    popped     = 0;
    prev_stall = 1'b0;
    rd_rst_n   = 1'b0;
    wr_ptr     = '0;
    m_ready    = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    @(negedge rd_clk);
    test_reset();
    test_single();
    test_stream();
    test_stall_full();
    test_wrap();
    test_random();
`ifdef FIFO_RD_ERR_EN
    test_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
